i2c_slave_ctrl: RTL and testbench
=================================

Name: i2c_slave_ctrl

Overview:
- Control FSM for the I2C slave. It sits directly upstream of the slave datapath: start/stop detectors, SIPO data input, count_8, check_addr, reg_sel, memory, gen_output and get_ack.
- Consumes the datapath status (start, stop, SCL edge strobes, bit-count done, addr_valid, received byte, register pointer, master ACK).
- Produces every datapath control level: shift/count enables, pointer load/increment, register write, ACK drive and read-data output enable.
- Implements write (pointer byte, then data bytes with auto-increment), read (streaming bytes with auto-increment), repeated START and STOP.

Parameters:
- NUM_REGS, 4, number of implemented registers; pointer values >= NUM_REGS are out of range.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  sticky START flag from start_detect
- stop  in  1  sticky STOP flag from stop_detect
- SCL_posedge  in  1  one-cycle SCL rising strobe
- SCL_negedge  in  1  one-cycle SCL falling strobe
- done  in  1  count_8 reached 8
- addr_valid  in  1  data_in[7:1] matches the slave address
- data_in  in  8  received byte; bit 0 is R/W during the address byte
- sel  in  5  current register pointer from reg_sel
- ACK  in  1  master ACK sampled by get_ack
- clear_start  out  1  clears the start flag
- clear_stop  out  1  clears the stop flag
- shift_en  out  1  enable for data_input shifting
- count_en  out  1  count_8 enable (level; qualify is internal: equals SCL_posedge in counting states)
- count_clear  out  1  count_8 clear
- sel_en  out  1  load pointer from data_in[4:0]
- sel_inc  out  1  increment pointer
- we  out  1  register write enable
- send_ack  out  1  drive SDA low for ACK
- out_en  out  1  drive memory serial bit onto SDA
- rw  out  1  latched R/W bit (1 = read)

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: state=IDLE and rw=0. During reset, clear_start=clear_stop=count_clear=1 and every other output is 0.
- All outputs are combinational decodes of the registered state, rw, ptr_ok and the inputs. The datapath qualifies sel_en, sel_inc and we with SCL_negedge, so these are levels held for the whole state.
- ptr_ok = (sel < NUM_REGS).
- Priority each cycle: reset > stop > start > normal transition.
- stop=1, any state: go to IDLE and assert clear_stop for that cycle.
- start=1, no stop: go to RECV_ADDR and assert clear_start and count_clear for that cycle. This covers repeated START mid-transfer. The pointer is not reset.
- States and transitions:
  - IDLE: count_clear=1. Wait for start.
  - RECV_ADDR: shift_en=1, count_en=SCL_posedge. On SCL_negedge with done:
    - latch rw=data_in[0];
    - if addr_valid, go to ADDR_ACK;
    - else go to WAIT_STOP (no ACK, SDA released).
  - ADDR_ACK: send_ack=1, count_clear=1. On the next SCL_negedge: go to SEND_DATA if rw=1, else RECV_REG.
  - RECV_REG: shift_en=1, count_en=SCL_posedge. On SCL_negedge with done, go to REG_ACK.
  - REG_ACK: send_ack=1, count_clear=1, sel_en=1 (pointer loads at the ACK-ending negedge). On the next SCL_negedge, go to RECV_DATA.
  - RECV_DATA: same as RECV_REG. On SCL_negedge with done, go to DATA_ACK.
  - DATA_ACK: count_clear=1. If ptr_ok: send_ack=1, we=1, sel_inc=1, and on the next SCL_negedge go to RECV_DATA. The write uses the old pointer and the increment happens at the same edge. If not ptr_ok: NACK (send_ack=0), no write, no increment, go to WAIT_STOP.
  - SEND_DATA: out_en=1, count_en=SCL_posedge. On SCL_negedge with done, go to MASTER_ACK.
  - MASTER_ACK: out_en=0, count_clear=1. On the next SCL_negedge:
    - ACK=1: sel_inc=1 and go to SEND_DATA;
    - ACK=0: go to WAIT_STOP.
  - WAIT_STOP: all outputs 0 except count_clear=1. Leave only via stop or start.
- Out-of-range pointer in a read: the memory contents are driven as-is. No NACK is possible because the master acknowledges reads.
- Pointer arithmetic is 5-bit and wraps 31->0 inside reg_sel; the FSM does not saturate it.

Decomposition:
- Package i2c_pkg holds:
  - state enum i2c_state_t {IDLE, RECV_ADDR, ADDR_ACK, RECV_REG, REG_ACK, RECV_DATA, DATA_ACK, SEND_DATA, MASTER_ACK, WAIT_STOP};
  - constant SLAVE_ADDR=7'h20;
  - default NUM_REGS=4.
- Single module, no sub-modules. The output decode is one always_comb block and the next-state logic is one always_comb block.

Test Plan:
- Write 0x40,[0x01],[0xA5],STOP -> ACKs on all three bytes; we high in DATA_ACK; registers[1]=0xA5; pointer ends at 2; state IDLE.
- Write burst 0x40,[0x00],[0x11],[0x22],[0x33],[0x44],[0x55] -> registers 0..3 = 11,22,33,44; the fifth byte is NACKed and not written; state WAIT_STOP.
- Write pointer 0x02, repeated START, 0x41, master ACK then NACK -> SEND_DATA twice with out_en high for 8 bits each; bytes from registers 2 and 3; WAIT_STOP after the NACK.
- Address 0x42 (wrong address) -> no send_ack; WAIT_STOP; further bytes ignored; next START plus 0x40 is ACKed.
- STOP injected mid-RECV_DATA after 4 bits -> IDLE the next cycle; clear_stop pulses; no write occurs.
- Reset asserted in SEND_DATA -> next cycle IDLE, out_en=0, rw=0, count_clear=1.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and constants for the I2C slave controller
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RECV_ADDR,
        ADDR_ACK,
        RECV_REG,
        REG_ACK,
        RECV_DATA,
        DATA_ACK,
        SEND_DATA,
        MASTER_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic [6:0] SLAVE_ADDR   = 7'h20;
    localparam int         DEF_NUM_REGS = 4;

endpackage

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: control FSM sequencing the I2C slave datapath
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       SCL_posedge,
    input  logic       SCL_negedge,
    input  logic       done,
    input  logic       addr_valid,
    input  logic [7:0] data_in,
    input  logic [4:0] sel,
    input  logic       ACK,
    output logic       clear_start,
    output logic       clear_stop,
    output logic       shift_en,
    output logic       count_en,
    output logic       count_clear,
    output logic       sel_en,
    output logic       sel_inc,
    output logic       we,
    output logic       send_ack,
    output logic       out_en,
    output logic       rw
);

    i2c_state_t state, state_n;
    logic       rw_q;
    logic       ptr_ok;
    logic       unused_bits;

    assign ptr_ok      = int'(sel) < NUM_REGS;
    assign unused_bits = ^data_in[7:1];
    assign rw          = rw_q && !reset;

    // next state: stop beats start, both beat the SCL-driven progression
    always_comb begin
        state_n = state;
        if (stop)
            state_n = IDLE;
        else if (start)
            state_n = RECV_ADDR;
        else if (SCL_negedge)
            case (state)
                RECV_ADDR:  if (done) state_n = addr_valid ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:   state_n = rw_q ? SEND_DATA : RECV_REG;
                RECV_REG:   if (done) state_n = REG_ACK;
                REG_ACK:    state_n = RECV_DATA;
                RECV_DATA:  if (done) state_n = DATA_ACK;
                DATA_ACK:   state_n = ptr_ok ? RECV_DATA : WAIT_STOP;
                SEND_DATA:  if (done) state_n = MASTER_ACK;
                MASTER_ACK: state_n = ACK ? SEND_DATA : WAIT_STOP;
                default:    state_n = state;
            endcase
    end

    // state register; R/W is captured at the edge that closes the address byte
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rw_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (!stop && !start && state == RECV_ADDR && SCL_negedge && done)
                rw_q <= data_in[0];
        end
    end

    // output decode; pointer/write controls are levels the datapath qualifies with SCL_negedge
    always_comb begin
        clear_start = 1'b0;
        clear_stop  = 1'b0;
        shift_en    = 1'b0;
        count_en    = 1'b0;
        count_clear = 1'b0;
        sel_en      = 1'b0;
        sel_inc     = 1'b0;
        we          = 1'b0;
        send_ack    = 1'b0;
        out_en      = 1'b0;
        if (reset) begin
            clear_start = 1'b1;
            clear_stop  = 1'b1;
            count_clear = 1'b1;
        end else if (stop) begin
            clear_stop = 1'b1;
        end else if (start) begin
            clear_start = 1'b1;
            count_clear = 1'b1;
        end else
            case (state)
                RECV_ADDR, RECV_REG, RECV_DATA: begin
                    shift_en = 1'b1;
                    count_en = SCL_posedge;
                end
                ADDR_ACK: begin
                    send_ack    = 1'b1;
                    count_clear = 1'b1;
                end
                REG_ACK: begin
                    send_ack    = 1'b1;
                    count_clear = 1'b1;
                    sel_en      = 1'b1;
                end
                DATA_ACK: begin
                    count_clear = 1'b1;
                    send_ack    = ptr_ok;
                    we          = ptr_ok;
                    sel_inc     = ptr_ok;
                end
                SEND_DATA: begin
                    out_en   = 1'b1;
                    count_en = SCL_posedge;
                end
                MASTER_ACK: begin
                    count_clear = 1'b1;
                    sel_inc     = ACK;
                end
                default: count_clear = 1'b1;
            endcase
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: closed-loop bench with datapath model and SCL-negedge scoreboard
module tb_i2c_slave_ctrl;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start, stop, start_req = 1'b0, stop_req = 1'b0;
    logic       SCL_posedge = 1'b0, SCL_negedge = 1'b0;
    logic       done, addr_valid, ACK = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [4:0] ptr;
    logic [3:0] cnt;
    logic [7:0] mem [4];
    logic       clear_start, clear_stop, shift_en, count_en, count_clear;
    logic       sel_en, sel_inc, we, send_ack, out_en, rw;

    typedef struct {
        logic [5:0] f;
        int         n;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   tag = 0;

    // flag vector {shift_en, out_en, send_ack, we, sel_en, sel_inc} seen at each SCL falling strobe
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] RBIT = 6'b100000;
    localparam logic [5:0] SBIT = 6'b010000;
    localparam logic [5:0] ACKA = 6'b001000;
    localparam logic [5:0] ACKR = 6'b001010;
    localparam logic [5:0] ACKD = 6'b001101;
    localparam logic [5:0] MINC = 6'b000001;

    i2c_slave_ctrl dut (
        .clock(clk), .reset(reset), .start(start), .stop(stop),
        .SCL_posedge(SCL_posedge), .SCL_negedge(SCL_negedge), .done(done),
        .addr_valid(addr_valid), .data_in(data_in), .sel(ptr), .ACK(ACK),
        .clear_start(clear_start), .clear_stop(clear_stop), .shift_en(shift_en),
        .count_en(count_en), .count_clear(count_clear), .sel_en(sel_en),
        .sel_inc(sel_inc), .we(we), .send_ack(send_ack), .out_en(out_en), .rw(rw)
    );

    always #5 clk = ~clk;

    assign done       = (cnt == 4'd8);
    assign addr_valid = (data_in[7:1] == SLAVE_ADDR);

    // datapath model: sticky flags, count_8, reg_sel pointer and register file
    always @(posedge clk) begin
        if (reset) begin
            start <= 1'b0;
            stop  <= 1'b0;
            cnt   <= 4'd0;
            ptr   <= 5'd0;
            for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
        end else begin
            start <= start_req | (start & ~clear_start);
            stop  <= stop_req | (stop & ~clear_stop);
            cnt   <= count_clear ? 4'd0 : (count_en && cnt < 4'd8) ? cnt + 4'd1 : cnt;
            if (SCL_negedge) begin
                if (sel_en) ptr <= data_in[4:0];
                else if (sel_inc) ptr <= ptr + 5'd1;
                if (we && ptr < 5'd4) mem[ptr[1:0]] <= data_in;
            end
        end
    end

    // monitor: every SCL falling strobe consumes one expected flag vector
    always @(negedge clk) begin
        if (SCL_negedge) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got %b required none queued", {shift_en, out_en, send_ack, we, sel_en, sel_inc});
            end else begin
                e_mon = q.pop_front();
                if ({shift_en, out_en, send_ack, we, sel_en, sel_inc} !== e_mon.f) begin
                    errors++;
                    $display("FAIL sb_byte%0d got %b required %b", e_mon.n, {shift_en, out_en, send_ack, we, sel_en, sel_inc}, e_mon.f);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_scl();
        SCL_posedge = 1'b1; tick();
        SCL_posedge = 1'b0; tick();
        SCL_negedge = 1'b1; tick();
        SCL_negedge = 1'b0; tick();
    endtask

    task automatic bits(input int n, input logic [5:0] f);
        for (int i = 0; i < n; i++) begin
            q.push_back('{f, tag});
            pulse_scl();
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic a, input logic [5:0] fb, input logic [5:0] fa);
        data_in = b;
        ACK = a;
        bits(8, fb);
        bits(1, fa);
        tag++;
    endtask

    task automatic do_start();
        start_req = 1'b1; tick();
        start_req = 1'b0;
        @(negedge clk);
        chk("clr_start", {31'd0, clear_start}, 1);
        chk("cnt_clr_start", {31'd0, count_clear}, 1);
        tick();
    endtask

    task automatic do_stop();
        stop_req = 1'b1; tick();
        stop_req = 1'b0;
        @(negedge clk);
        chk("clr_stop", {31'd0, clear_stop}, 1);
        chk("stop_no_we", {31'd0, we}, 0);
        tick();
        @(negedge clk);
        chk("stop_idle", 32'(dut.state), 32'(IDLE));
        chk("stop_flag_cleared", {31'd0, stop}, 0);
        tick();
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_clr"}, {29'd0, clear_start, clear_stop, count_clear}, 32'h7);
        chk({name, "_zero"}, {24'd0, shift_en, count_en, sel_en, sel_inc, we, send_ack, out_en, rw}, 0);
    endtask

    initial begin
        tick(); tick();
        @(negedge clk);
        chk_reset_outs("rst");
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle", 32'(dut.state), 32'(IDLE));
        tick();

        // single register write: 0x40, pointer 1, data A5
        do_start();
        xfer(8'h40, 1'b0, RBIT, ACKA);
        chk("wr_rw", {31'd0, rw}, 0);
        xfer(8'h01, 1'b0, RBIT, ACKR);
        xfer(8'hA5, 1'b0, RBIT, ACKD);
        do_stop();
        chk("wr_mem1", {24'd0, mem[1]}, 32'hA5);
        chk("wr_ptr", {27'd0, ptr}, 2);

        // burst write running past the last register
        do_start();
        xfer(8'h40, 1'b0, RBIT, ACKA);
        xfer(8'h00, 1'b0, RBIT, ACKR);
        xfer(8'h11, 1'b0, RBIT, ACKD);
        xfer(8'h22, 1'b0, RBIT, ACKD);
        xfer(8'h33, 1'b0, RBIT, ACKD);
        xfer(8'h44, 1'b0, RBIT, ACKD);
        xfer(8'h55, 1'b0, RBIT, NONE);
        @(negedge clk);
        chk("burst_wait_stop", 32'(dut.state), 32'(WAIT_STOP));
        chk("burst_cnt_clr", {31'd0, count_clear}, 1);
        chk("burst_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h11223344);
        chk("burst_ptr", {27'd0, ptr}, 4);
        tick();
        do_stop();

        // pointer write, repeated START, read two bytes
        do_start();
        xfer(8'h40, 1'b0, RBIT, ACKA);
        xfer(8'h02, 1'b0, RBIT, ACKR);
        do_start();
        xfer(8'h41, 1'b0, RBIT, ACKA);
        chk("rd_rw", {31'd0, rw}, 1);
        chk("rd_ptr0", {27'd0, ptr}, 2);
        xfer(8'h00, 1'b1, SBIT, MINC);
        chk("rd_ptr1", {27'd0, ptr}, 3);
        xfer(8'h00, 1'b0, SBIT, NONE);
        @(negedge clk);
        chk("rd_wait_stop", 32'(dut.state), 32'(WAIT_STOP));
        chk("rd_ptr_end", {27'd0, ptr}, 3);
        tick();
        do_stop();

        // foreign address is ignored until the next START
        do_start();
        xfer(8'h42, 1'b0, RBIT, NONE);
        @(negedge clk);
        chk("na_wait_stop", 32'(dut.state), 32'(WAIT_STOP));
        tick();
        xfer(8'h40, 1'b0, NONE, NONE);
        do_start();
        xfer(8'h40, 1'b0, RBIT, ACKA);
        @(negedge clk);
        chk("na_recv_reg", 32'(dut.state), 32'(RECV_REG));
        tick();
        do_stop();

        // STOP in the middle of a data byte
        do_start();
        xfer(8'h40, 1'b0, RBIT, ACKA);
        xfer(8'h03, 1'b0, RBIT, ACKR);
        data_in = 8'hEE;
        bits(4, RBIT);
        do_stop();
        chk("mid_stop_mem3", {24'd0, mem[3]}, 32'h44);
        chk("mid_stop_ptr", {27'd0, ptr}, 3);

        // reset during a read byte
        do_start();
        xfer(8'h41, 1'b0, RBIT, ACKA);
        bits(4, SBIT);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst_rd");
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_idle", 32'(dut.state), 32'(IDLE));
        chk("rst_rd_outs", {29'd0, out_en, rw, count_clear}, 32'h1);
        chk("sb_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
